// File: rtl/ntt_issue_ctrl.sv
// NTT butterfly issue controller: walks stages/butterflies, issues
// operand reads and replays their addresses as PE write-backs.
module ntt_issue_ctrl #(
  parameter int LOG_N  = 9,
  parameter int RD_LAT = 1,
  parameter int PE_LAT = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  output logic             rd_en,
  output logic [LOG_N-1:0] rd_addr_u,
  output logic [LOG_N-1:0] rd_addr_v,
  output logic [LOG_N-1:0] tw_addr,
  output logic             sel,
  output logic             wr_en,
  output logic [LOG_N-1:0] wr_addr_sum,
  output logic [LOG_N-1:0] wr_addr_diff,
  output logic             busy,
  output logic             done
);

  localparam int KW  = LOG_N - 1;
  localparam int SW  = $clog2(LOG_N + 1);
  localparam int DLY = RD_LAT + PE_LAT;
  localparam int DCW = $clog2(DLY + 1);

  localparam logic [SW-1:0] LAST_S = SW'(LOG_N - 1);
  localparam logic [SW-1:0] LOG_V  = SW'(LOG_N);
  localparam logic [KW-1:0] LAST_K = '1;
  localparam logic [DCW-1:0] LAST_D = DCW'(DLY - 1);
  localparam logic [LOG_N-1:0] HALF_V = {1'b1, {(LOG_N-1){1'b0}}};
  localparam logic [LOG_N-1:0] ONE_V  = {{(LOG_N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  s_q, s_d;
  logic [KW-1:0]  k_q, k_d;
  logic [DCW-1:0] dc_q, dc_d;
  logic           sel_q, sel_d;

  logic [DLY-1:0] wv_q, wv_d;
  logic [LOG_N-1:0] wu_q [DLY];
  logic [LOG_N-1:0] wu_d [DLY];
  logic [LOG_N-1:0] wd_q [DLY];
  logic [LOG_N-1:0] wd_d [DLY];

  logic [LOG_N-1:0] k_ext, len, g;
  logic [LOG_N-1:0] u_c, v_c, tw_c;
  logic [SW-1:0]    sh_g, sh_u;
  logic             run;

  // Address generation straight from the stage/butterfly counters
  always_comb begin
    k_ext = {1'b0, k_q};
    len   = HALF_V >> s_q;
    sh_g  = LAST_S - s_q;
    sh_u  = LOG_V - s_q;
    g     = k_ext >> sh_g;
    u_c   = (g << sh_u) | (k_ext & (len - ONE_V));
    v_c   = u_c + len;
    tw_c  = (ONE_V << s_q) + g;
  end

  assign run       = (state_q == RUN);
  assign rd_en     = run;
  assign rd_addr_u = run ? u_c : '0;
  assign rd_addr_v = run ? v_c : '0;
  assign tw_addr   = run ? tw_c : '0;
  assign sel       = sel_q;
  assign busy      = run || (state_q == DRAIN);
  assign done      = (state_q == FIN);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    dc_d    = dc_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          sel_d   = mode;
          s_d     = '0;
          k_d     = '0;
        end
      end
      RUN: begin
        k_d = k_q + 1'b1;
        if (k_q == LAST_K) begin
          k_d     = '0;
          dc_d    = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        dc_d = dc_q + 1'b1;
        if (dc_q == LAST_D) begin
          dc_d = '0;
          if (s_q == LAST_S) begin
            s_d     = '0;
            state_d = FIN;
          end else begin
            s_d     = s_q + 1'b1;
            state_d = RUN;
          end
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write-back replays the issued pair once operands clear RAM and PE
  always_comb begin
    wv_d[0] = rd_en;
    wu_d[0] = rd_addr_u;
    wd_d[0] = rd_addr_v;
    for (int i = 1; i < DLY; i++) begin
      wv_d[i] = wv_q[i-1];
      wu_d[i] = wu_q[i-1];
      wd_d[i] = wd_q[i-1];
    end
  end

  assign wr_en        = wv_q[DLY-1];
  assign wr_addr_sum  = wu_q[DLY-1];
  assign wr_addr_diff = wd_q[DLY-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      dc_q    <= '0;
      sel_q   <= 1'b0;
      wv_q    <= '0;
      for (int i = 0; i < DLY; i++) begin
        wu_q[i] <= '0;
        wd_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      dc_q    <= dc_d;
      sel_q   <= sel_d;
      wv_q    <= wv_d;
      for (int i = 0; i < DLY; i++) begin
        wu_q[i] <= wu_d[i];
        wd_q[i] <= wd_d[i];
      end
    end
  end

endmodule

// File: tb/tb_ntt_issue_ctrl.sv
// Directed bench for ntt_issue_ctrl at default parameters
// (N=512, read+PE latency 7, 263 cycles per stage).
module tb_ntt_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic       rd_en, sel, wr_en, busy, done;
  logic [8:0] rd_addr_u, rd_addr_v, tw_addr;
  logic [8:0] wr_addr_sum, wr_addr_diff;

  int checks = 0;
  int failures = 0;

  ntt_issue_ctrl dut (
    .clk(clk),
    .rst(rst_n),
    .start(start),
    .mode(mode),
    .rd_en(rd_en),
    .rd_addr_u(rd_addr_u),
    .rd_addr_v(rd_addr_v),
    .tw_addr(tw_addr),
    .sel(sel),
    .wr_en(wr_en),
    .wr_addr_sum(wr_addr_sum),
    .wr_addr_diff(wr_addr_diff),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle c after the start cycle (c=0): expected issue for that cycle
  function automatic void model(input int c, output logic en,
                                output logic [8:0] u, output logic [8:0] v,
                                output logic [8:0] tw);
    int st, off, len, g, j;
    en = 1'b0; u = '0; v = '0; tw = '0;
    if (c >= 1 && c <= 9 * 263) begin
      st  = (c - 1) / 263;
      off = (c - 1) % 263;
      if (off < 256) begin
        len = 256 >> st;
        g   = off / len;
        j   = off % len;
        u   = 9'(g * 2 * len + j);
        v   = 9'(g * 2 * len + j + len);
        tw  = 9'((1 << st) + g);
        en  = 1'b1;
      end
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (rd_en !== 1'b0 || wr_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_en rd=%b wr=%b want 0 0", rd_en, wr_en);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_status busy=%b done=%b want 0 0", busy, done);
    end
    checks++;
    if (sel !== 1'b0) begin
      failures++;
      $display("FAIL reset_sel got %b want 0", sel);
    end
    checks++;
    if ({rd_addr_u, rd_addr_v, tw_addr} !== 27'd0) begin
      failures++;
      $display("FAIL reset_rd_addr u=%0d v=%0d tw=%0d want 0",
               rd_addr_u, rd_addr_v, tw_addr);
    end
    checks++;
    if ({wr_addr_sum, wr_addr_diff} !== 18'd0) begin
      failures++;
      $display("FAIL reset_wr_addr s=%0d d=%0d want 0",
               wr_addr_sum, wr_addr_diff);
    end
    step();
    step();
    #2 rst_n = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || rd_en !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_start busy=%b rd=%b want 0 0", busy, rd_en);
    end
  endtask

  // Full transform; poke adds a mid-run start and a start during done
  task automatic test_run(input logic m, input bit poke);
    int   rd_err = 0, wr_err = 0, st_err = 0, sel_err = 0;
    int   rd_cnt = 0, wr_cnt = 0, done_cyc = -1;
    logic e_en, w_en;
    logic [8:0] e_u, e_v, e_tw, w_u, w_v, w_tw;
    start = 1'b1;
    mode  = m;
    for (int c = 1; c <= 2372; c++) begin
      step();
      start = 1'b0;
      mode  = m;
      if (poke && (c == 100 || c == 2368)) begin
        start = 1'b1;
        mode  = ~m;
      end
      model(c, e_en, e_u, e_v, e_tw);
      model(c - 7, w_en, w_u, w_v, w_tw);
      if (rd_en) rd_cnt++;
      if (wr_en) wr_cnt++;
      if (done === 1'b1 && done_cyc < 0) done_cyc = c;
      if (rd_en !== e_en) rd_err++;
      else if (e_en && (rd_addr_u !== e_u || rd_addr_v !== e_v ||
                        tw_addr !== e_tw)) rd_err++;
      if (wr_en !== w_en) wr_err++;
      else if (w_en && (wr_addr_sum !== w_u ||
                        wr_addr_diff !== w_v)) wr_err++;
      if (busy !== (c >= 1 && c <= 2367) || done !== (c == 2368)) st_err++;
      if (sel !== m) sel_err++;
      if (c == 1) begin
        checks++;
        if (rd_en !== 1'b1 || rd_addr_u !== 9'd0 || rd_addr_v !== 9'd256 ||
            tw_addr !== 9'd1) begin
          failures++;
          $display("FAIL s0_first en=%b u=%0d v=%0d tw=%0d want 1 0 256 1",
                   rd_en, rd_addr_u, rd_addr_v, tw_addr);
        end
      end
      if (c == 256) begin
        checks++;
        if (rd_addr_u !== 9'd255 || rd_addr_v !== 9'd511 ||
            tw_addr !== 9'd1) begin
          failures++;
          $display("FAIL s0_last u=%0d v=%0d tw=%0d want 255 511 1",
                   rd_addr_u, rd_addr_v, tw_addr);
        end
      end
      if (c == 263) begin
        checks++;
        if (wr_en !== 1'b1 || wr_addr_sum !== 9'd255 ||
            wr_addr_diff !== 9'd511 || rd_en !== 1'b0) begin
          failures++;
          $display("FAIL s0_wb wr=%b s=%0d d=%0d rd=%b want 1 255 511 0",
                   wr_en, wr_addr_sum, wr_addr_diff, rd_en);
        end
      end
      if (c == 392) begin
        checks++;
        if (rd_addr_u !== 9'd256 || rd_addr_v !== 9'd384 ||
            tw_addr !== 9'd3) begin
          failures++;
          $display("FAIL s1_k128 u=%0d v=%0d tw=%0d want 256 384 3",
                   rd_addr_u, rd_addr_v, tw_addr);
        end
      end
      if (c == 2105) begin
        checks++;
        if (rd_en !== 1'b1 || rd_addr_u !== 9'd0 || rd_addr_v !== 9'd1 ||
            tw_addr !== 9'd256) begin
          failures++;
          $display("FAIL s8_k0 en=%b u=%0d v=%0d tw=%0d want 1 0 1 256",
                   rd_en, rd_addr_u, rd_addr_v, tw_addr);
        end
      end
      if (c == 2360) begin
        checks++;
        if (rd_addr_u !== 9'd510 || rd_addr_v !== 9'd511 ||
            tw_addr !== 9'd511) begin
          failures++;
          $display("FAIL s8_k255 u=%0d v=%0d tw=%0d want 510 511 511",
                   rd_addr_u, rd_addr_v, tw_addr);
        end
      end
    end
    start = 1'b0;
    mode  = m;
    checks++;
    if (done_cyc != 2368) begin
      failures++;
      $display("FAIL done_cycle got %0d want 2368", done_cyc);
    end
    checks++;
    if (rd_cnt != 2304 || wr_cnt != 2304) begin
      failures++;
      $display("FAIL op_counts rd=%0d wr=%0d want 2304 2304", rd_cnt, wr_cnt);
    end
    checks++;
    if (rd_err != 0) begin
      failures++;
      $display("FAIL rd_stream bad_cycles=%0d want 0", rd_err);
    end
    checks++;
    if (wr_err != 0) begin
      failures++;
      $display("FAIL wr_stream bad_cycles=%0d want 0", wr_err);
    end
    checks++;
    if (st_err != 0) begin
      failures++;
      $display("FAIL busy_done bad_cycles=%0d want 0", st_err);
    end
    checks++;
    if (sel_err != 0) begin
      failures++;
      $display("FAIL sel_hold bad_cycles=%0d want 0 (mode %b)", sel_err, m);
    end
  endtask

  task automatic test_reset_mid_run();
    int bad = 0;
    start = 1'b1;
    mode  = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      step();
      start = 1'b0;
    end
    checks++;
    if (sel !== 1'b1 || rd_en !== 1'b1) begin
      failures++;
      $display("FAIL pre_abort sel=%b rd=%b want 1 1", sel, rd_en);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rd_en !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || sel !== 1'b0) begin
      failures++;
      $display("FAIL abort_async rd=%b wr=%b busy=%b done=%b sel=%b want 0",
               rd_en, wr_en, busy, done, sel);
    end
    checks++;
    if ({rd_addr_u, rd_addr_v, tw_addr, wr_addr_sum, wr_addr_diff} !== 45'd0)
    begin
      failures++;
      $display("FAIL abort_addr u=%0d v=%0d tw=%0d s=%0d d=%0d want 0",
               rd_addr_u, rd_addr_v, tw_addr, wr_addr_sum, wr_addr_diff);
    end
    step();
    step();
    #2 rst_n = 1'b1;
    mode = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (wr_en !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL post_abort_quiet bad_cycles=%0d want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_run(1'b1, 1'b1);
    test_reset_mid_run();
    test_run(1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
